pueo_trig_source_arbiter: RTL and testbench
===========================================

# pueo_trig_source_arbiter

Sequences the PUEO master trigger path: collects single-cycle trigger requests from NSRC sources (RF/leveltwo, soft, PPS, external), timestamps each one, subtracts a per-source offset, and issues them one at a time as trigger words on an AXI4-Stream-minimal output. Round-robin arbitration, one-deep pending slot per source with drop counting, and a programmable post-trigger holdoff. Sits in the sysclk domain between the trigger generators and the TURF trigger/header builder.

## Interface
Parameters:
- NSRC, 4: number of request sources (2..8).
- TBITS, 32: timestamp width.

Ports:
- sysclk_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- run_i  in  1  run enable; low = idle and clear.
- cur_time_i  in  TBITS  free-running sysclk timestamp.
- req_i  in  NSRC  per-source single-cycle request pulses.
- offset_i  in  NSRC*16  per-source offset; slice k = [16k +: 16].
- holdoff_i  in  16  cycles of deadtime after each accepted trigger.
- trigout_tdata  out  48  [TBITS-1:0] trigger time, [35:32] source index, [47:36] zero.
- trigout_tvalid  out  1  output valid.
- trigout_tready  in  1  downstream ready.
- drop_count_o  out  NSRC*16  per-source saturating drop counters.
- trig_count_o  out  32  triggers handshaked this run.
- busy_o  out  1  high in ISSUE or HOLDOFF.

## Operation
- Capture: request k accepted when run_i=1 and slot k free (free = pending[k]=0 or slot k being loaded this cycle). Stores stamp[k] = cur_time_i − offset_k, modulo 2^TBITS, offset zero-extended.
- Drop: request on an occupied slot (not being loaded) is discarded; drop_count[k] +1, saturating at 0xFFFF.
- next pending = (pending & ~load_mask) | accept_mask.
- FSM IDLE / ISSUE / HOLDOFF:
  - IDLE: if any pending, select first pending index at or after rr_ptr (wrapping), load tdata = {12'h0, 4'(sel), stamp[sel]}, clear pending[sel], rr_ptr ← sel+1 mod NSRC, tvalid=1 → ISSUE.
  - ISSUE: hold tdata/tvalid stable until tready. On handshake: tvalid=0, trig_count+1; holdoff_i=0 → IDLE, else load hcnt=holdoff_i → HOLDOFF.
  - HOLDOFF: hcnt−1 each cycle; at hcnt=1 → IDLE. Requests still captured/dropped during HOLDOFF.
- run_i low (synchronous, each cycle): pending, stamps, drop counters, trig_count, rr_ptr cleared; FSM → IDLE; tvalid forced 0 (an unaccepted word is discarded).
- holdoff_i sampled only at ISSUE handshake; later changes affect the next trigger only.

## Timing
- Reset: all outputs 0, FSM IDLE, rr_ptr 0, pending 0.
- Request sampled at edge E0 (with cur_time_i at E0); earliest tvalid after edge E1 (2-cycle latency).
- Back-to-back with holdoff_i=0 and tready=1: one trigger per 2 cycles (ISSUE, IDLE).
- With holdoff H>0: next tvalid no earlier than H+1 cycles after previous handshake.
- Simultaneous requests: all captured in the same cycle; issue order is round-robin from rr_ptr.
- Request on the cycle its own slot is loaded: accepted, not dropped.
- Timestamp wrap: cur_time_i < offset yields modular wrap, no flag.
- Reset asserted mid-ISSUE: tvalid drops asynchronously; pending word lost.

## Structure
- Shared package pueo_trig_pkg: state enum (IDLE, ISSUE, HOLDOFF), tdata field offsets/widths, source index constants (SRC_RF=0, SRC_SOFT=1, SRC_PPS=2, SRC_EXT=3).
- One sub-module: pueo_rr_select (NSRC pending mask + rr_ptr → sel index and valid), combinational.
- Capture/drop logic generated per source within this module.

## Test plan
- Single soft request (k=1, offset 100) at cur_time 1000, tready=1 → tvalid 2 cycles later, tdata = {12'h0, 4'h1, 32'd900}, trig_count=1.
- Requests on all 4 sources same cycle, holdoff 0, rr_ptr 0 → issued order 0,1,2,3, every 2 cycles; then simultaneous again → order 0,1,2,3 (ptr wrapped).
- tready low 20 cycles with pending[2] set, second req on k=2 → drop_count[2]=1, tdata unchanged during stall; third req on k=2 after the load cycle → accepted.
- holdoff_i=10, two requests → second tvalid exactly 11 cycles after first handshake; busy_o high throughout.
- cur_time 50, offset 100 → stamp 0xFFFFFFCE; 70000 drops on one source → counter stays 0xFFFF.
- run_i dropped while tvalid=1 and pending set → next cycle tvalid=0, all counters 0; rst_i pulsed mid-HOLDOFF → immediate return to reset values.

Source files
------------

// File: rtl/pueo_trig_pkg.sv
// Shared types and constants for the PUEO master trigger source arbiter.
// Trigger word layout: [TBITS-1:0] time, [35:32] source index, rest zero.
package pueo_trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } trig_state_e;

  localparam int TDATA_W     = 48;
  localparam int TD_TIME_LSB = 0;
  localparam int TD_SRC_LSB  = 32;
  localparam int TD_SRC_W    = 4;

  localparam int OFFSET_W   = 16;
  localparam int HOLDOFF_W  = 16;
  localparam int DROP_W     = 16;
  localparam int TRIG_CNT_W = 32;

  localparam int SRC_RF   = 0;
  localparam int SRC_SOFT = 1;
  localparam int SRC_PPS  = 2;
  localparam int SRC_EXT  = 3;

endpackage

// File: rtl/pueo_rr_select.sv
// Round-robin picker: first set bit of pending_i at or after ptr_i, wrapping.
// Purely combinational; valid_o low when nothing is pending.
module pueo_rr_select #(
  parameter int NSRC = 4,
  parameter int PW   = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] pending_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [PW-1:0]   sel_o,
  output logic            valid_o
);

  always_comb begin
    logic [PW-1:0] idx;
    sel_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    // Walk from farthest to nearest so the nearest hit is the last write.
    for (int i = NSRC - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr_i) + i) % NSRC);
      if (pending_i[idx]) begin
        sel_o   = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pueo_trig_source_arbiter.sv
// Collects per-source trigger pulses, timestamps them minus a per-source offset,
// and issues them one at a time round-robin on a stream output with holdoff.
module pueo_trig_source_arbiter
  import pueo_trig_pkg::*;
#(
  parameter int NSRC  = 4,
  parameter int TBITS = 32
) (
  input  logic                   sysclk_i,
  input  logic                   rst_i,
  input  logic                   run_i,
  input  logic [TBITS-1:0]       cur_time_i,
  input  logic [NSRC-1:0]        req_i,
  input  logic [NSRC*16-1:0]     offset_i,
  input  logic [15:0]            holdoff_i,
  output logic [47:0]            trigout_tdata,
  output logic                   trigout_tvalid,
  input  logic                   trigout_tready,
  output logic [NSRC*16-1:0]     drop_count_o,
  output logic [31:0]            trig_count_o,
  output logic                   busy_o
);

  localparam int PW = $clog2(NSRC);

  trig_state_e                     state_q, state_d;
  logic [NSRC-1:0]                 pending_q, pending_d;
  logic [NSRC-1:0]                 accept_mask, drop_mask, free_mask, load_mask;
  logic [NSRC-1:0][TBITS-1:0]      stamp_q, stamp_d;
  logic [NSRC-1:0][DROP_W-1:0]     drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]                   sel;
  logic                            sel_valid;
  logic [TDATA_W-1:0]              tdata_q, tdata_d;
  logic                            tvalid_q, tvalid_d;
  logic [HOLDOFF_W-1:0]            hcnt_q, hcnt_d;
  logic [TRIG_CNT_W-1:0]           trig_cnt_q, trig_cnt_d;

  pueo_rr_select #(
    .NSRC (NSRC),
    .PW   (PW)
  ) u_rr_select (
    .pending_i (pending_q),
    .ptr_i     (rr_ptr_q),
    .sel_o     (sel),
    .valid_o   (sel_valid)
  );

  // A slot being handed to the output this cycle counts as free, so a new
  // request landing on that same edge is kept instead of dropped.
  for (genvar k = 0; k < NSRC; k++) begin : g_src
    logic [OFFSET_W-1:0] offset_k;
    assign offset_k       = offset_i[OFFSET_W*k +: OFFSET_W];
    assign free_mask[k]   = ~pending_q[k] | load_mask[k];
    assign accept_mask[k] = run_i & req_i[k] & free_mask[k];
    assign drop_mask[k]   = run_i & req_i[k] & ~free_mask[k];
    assign stamp_d[k]     = !run_i         ? '0 :
                            accept_mask[k] ? cur_time_i - TBITS'(offset_k) :
                                             stamp_q[k];
    assign drop_cnt_d[k]  = !run_i ? '0 :
                            (drop_mask[k] && (drop_cnt_q[k] != '1)) ? drop_cnt_q[k] + 1'b1 :
                                                                      drop_cnt_q[k];
  end

  assign pending_d = run_i ? ((pending_q & ~load_mask) | accept_mask) : '0;

  // Output stream: a word is transferred on any edge with tvalid and tready
  // both high; once raised, tvalid and tdata hold until that transfer.
  always_comb begin
    state_d    = state_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    hcnt_d     = hcnt_q;
    rr_ptr_d   = rr_ptr_q;
    trig_cnt_d = trig_cnt_q;
    load_mask  = '0;
    if (!run_i) begin
      state_d    = ST_IDLE;
      tvalid_d   = 1'b0;
      tdata_d    = '0;
      hcnt_d     = '0;
      rr_ptr_d   = '0;
      trig_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_valid) begin
            load_mask                            = NSRC'(1) << sel;
            tdata_d                              = '0;
            tdata_d[TD_TIME_LSB +: TBITS]        = stamp_q[sel];
            tdata_d[TD_SRC_LSB +: TD_SRC_W]      = TD_SRC_W'(sel);
            tvalid_d                             = 1'b1;
            rr_ptr_d = (sel == PW'(NSRC - 1)) ? '0 : sel + PW'(1);
            state_d  = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (trigout_tready) begin
            tvalid_d   = 1'b0;
            trig_cnt_d = trig_cnt_q + 1'b1;
            if (holdoff_i == '0) begin
              state_d = ST_IDLE;
            end else begin
              hcnt_d  = holdoff_i;
              state_d = ST_HOLDOFF;
            end
          end
        end
        ST_HOLDOFF: begin
          hcnt_d = hcnt_q - 1'b1;
          if (hcnt_q == HOLDOFF_W'(1)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      stamp_q    <= '0;
      drop_cnt_q <= '0;
      rr_ptr_q   <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      hcnt_q     <= '0;
      trig_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      stamp_q    <= stamp_d;
      drop_cnt_q <= drop_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      hcnt_q     <= hcnt_d;
      trig_cnt_q <= trig_cnt_d;
    end
  end

  assign trigout_tdata  = tdata_q;
  assign trigout_tvalid = tvalid_q;
  assign drop_count_o   = drop_cnt_q;
  assign trig_count_o   = trig_cnt_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pueo_trig_source_arbiter.sv
// Directed bench for the trigger source arbiter: inputs change and outputs are
// checked on the falling edge, with every expected value worked out by hand.
module tb_pueo_trig_source_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        run_i;
  logic [31:0] cur_time_i;
  logic [3:0]  req_i;
  logic [63:0] offset_i;
  logic [15:0] holdoff_i;
  logic [47:0] trigout_tdata;
  logic        trigout_tvalid;
  logic        trigout_tready;
  logic [63:0] drop_count_o;
  logic [31:0] trig_count_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pueo_trig_source_arbiter #(.NSRC(4), .TBITS(32)) dut (
    .sysclk_i       (clk),
    .rst_i          (rst_i),
    .run_i          (run_i),
    .cur_time_i     (cur_time_i),
    .req_i          (req_i),
    .offset_i       (offset_i),
    .holdoff_i      (holdoff_i),
    .trigout_tdata  (trigout_tdata),
    .trigout_tvalid (trigout_tvalid),
    .trigout_tready (trigout_tready),
    .drop_count_o   (drop_count_o),
    .trig_count_o   (trig_count_o),
    .busy_o         (busy_o)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] word(input int src, input logic [31:0] t);
    return {12'h0, 4'(src), t};
  endfunction

  initial begin
    rst_i = 1'b1; run_i = 1'b0; cur_time_i = '0; req_i = '0;
    offset_i = '0; holdoff_i = '0; trigout_tready = 1'b0;
    tick(2);

    // reset state
    check("rst_tvalid", trigout_tvalid, 0);
    check("rst_tdata", trigout_tdata, 0);
    check("rst_trig_count", trig_count_o, 0);
    check("rst_drop_count", drop_count_o, 0);
    check("rst_busy", busy_o, 0);
    rst_i = 1'b0;
    run_i = 1'b1;
    trigout_tready = 1'b1;
    offset_i[16*1 +: 16] = 16'd100;
    tick;

    // single soft request: 2-cycle latency, stamp = 1000 - 100
    cur_time_i = 32'd1000; req_i = 4'b0010;
    tick; req_i = '0;
    check("t1_tvalid_e0", trigout_tvalid, 0);
    tick;
    check("t1_tvalid", trigout_tvalid, 1);
    check("t1_tdata", trigout_tdata, word(1, 32'd900));
    check("t1_busy", busy_o, 1);
    tick;
    check("t1_tvalid_after", trigout_tvalid, 0);
    check("t1_trig_count", trig_count_o, 1);

    // clear via run_i so the round-robin pointer restarts at 0
    run_i = 1'b0; tick;
    check("t2_run_clear_count", trig_count_o, 0);
    run_i = 1'b1; tick;

    // two rounds of simultaneous requests: order 0,1,2,3 each time
    for (int r = 0; r < 2; r++) begin
      cur_time_i = (r == 0) ? 32'd2000 : 32'd3000;
      req_i = 4'hF;
      tick; req_i = '0;
      check("t2_cap_tvalid", trigout_tvalid, 0);
      for (int i = 0; i < 4; i++) begin
        tick;
        check("t2_tvalid", trigout_tvalid, 1);
        check("t2_tdata", trigout_tdata, word(i, cur_time_i - ((i == 1) ? 32'd100 : 32'd0)));
        tick;
        check("t2_gap", trigout_tvalid, 0);
      end
      check("t2_trig_count", trig_count_o, 4 * (r + 1));
    end

    // stall with slot 2 pending, then a dropped request
    trigout_tready = 1'b0;
    cur_time_i = 32'd4000; req_i = 4'b0100;
    tick; req_i = '0;
    tick;
    check("t3_tvalid", trigout_tvalid, 1);
    check("t3_tdata", trigout_tdata, word(2, 32'd4000));
    cur_time_i = 32'd4100; req_i = 4'b0100;
    tick;
    cur_time_i = 32'd4200;
    tick; req_i = '0;
    check("t3_drop2", drop_count_o[32 +: 16], 1);
    for (int i = 0; i < 20; i++) begin
      tick;
      check("t3_stall_tvalid", trigout_tvalid, 1);
      check("t3_stall_tdata", trigout_tdata, word(2, 32'd4000));
    end
    trigout_tready = 1'b1;
    tick;
    check("t3_hs_tvalid", trigout_tvalid, 0);
    // request arrives on the edge slot 2 is loaded: kept, not dropped
    cur_time_i = 32'd4300; req_i = 4'b0100;
    tick; req_i = '0;
    check("t3_load_tdata", trigout_tdata, word(2, 32'd4100));
    check("t3_load_drop2", drop_count_o[32 +: 16], 1);
    tick;
    check("t3_gap", trigout_tvalid, 0);
    tick;
    check("t3_third_tvalid", trigout_tvalid, 1);
    check("t3_third_tdata", trigout_tdata, word(2, 32'd4300));
    tick;
    check("t3_trig_count", trig_count_o, 11);

    // holdoff 10: rr_ptr is 3, so source 3 then source 0
    holdoff_i = 16'd10;
    cur_time_i = 32'd5000; req_i = 4'b1001;
    tick; req_i = '0;
    tick;
    check("t4_first_tdata", trigout_tdata, word(3, 32'd5000));
    tick;
    for (int j = 0; j <= 11; j++) begin
      if (j == 2) holdoff_i = 16'd3;
      if (j <= 9) begin
        check("t4_hold_busy", busy_o, 1);
        check("t4_hold_tvalid", trigout_tvalid, 0);
      end else if (j == 10) begin
        check("t4_idle_busy", busy_o, 0);
        check("t4_idle_tvalid", trigout_tvalid, 0);
      end else begin
        check("t4_second_tvalid", trigout_tvalid, 1);
        check("t4_second_tdata", trigout_tdata, word(0, 32'd5000));
      end
      if (j < 11) tick;
    end
    tick;
    check("t4_hold3_busy", busy_o, 1);
    holdoff_i = 16'd0;
    tick(3);
    check("t4_hold3_done", busy_o, 0);
    check("t4_trig_count", trig_count_o, 13);

    // timestamp wrap: 50 - 100
    cur_time_i = 32'd50; req_i = 4'b0010;
    tick; req_i = '0;
    tick;
    check("t5_wrap_tdata", trigout_tdata, word(1, 32'hFFFF_FFCE));
    tick;

    // drop counter saturation on source 0 with output stalled
    trigout_tready = 1'b0;
    req_i = 4'b0001;
    tick(65536);
    check("t5_drop_fffe", drop_count_o[0 +: 16], 16'hFFFE);
    tick;
    check("t5_drop_ffff", drop_count_o[0 +: 16], 16'hFFFF);
    tick(4463);
    req_i = '0;
    check("t5_drop_sat", drop_count_o[0 +: 16], 16'hFFFF);
    check("t5_stall_tdata", trigout_tdata, word(0, 32'd50));

    // run_i low mid-ISSUE with slot 0 pending
    check("t6_pre_tvalid", trigout_tvalid, 1);
    run_i = 1'b0;
    tick;
    check("t6_tvalid", trigout_tvalid, 0);
    check("t6_trig_count", trig_count_o, 0);
    check("t6_drop_count", drop_count_o, 0);
    check("t6_busy", busy_o, 0);
    run_i = 1'b1; trigout_tready = 1'b1;
    tick(3);
    check("t6_pending_cleared", trigout_tvalid, 0);

    // reset pulse in HOLDOFF, with slot 2 pending
    holdoff_i = 16'd20;
    cur_time_i = 32'd6000; req_i = 4'b0010;
    tick; req_i = '0;
    tick;
    check("t7_tdata", trigout_tdata, word(1, 32'd5900));
    tick;
    cur_time_i = 32'd6100; req_i = 4'b0100;
    tick; req_i = '0;
    tick;
    check("t7_hold_busy", busy_o, 1);
    check("t7_trig_count", trig_count_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check("t7_rst_busy", busy_o, 0);
    check("t7_rst_trig_count", trig_count_o, 0);
    check("t7_rst_tvalid", trigout_tvalid, 0);
    @(negedge clk);
    rst_i = 1'b0;
    tick(4);
    check("t7_post_tvalid", trigout_tvalid, 0);
    check("t7_post_busy", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
